lfsr_frame_sched: RTL and testbench
===================================

Name: lfsr_frame_sched

Overview:
- Frame sequencer for the 22-bit maximal-length LFSR test-data source in the modulator transmit path.
- Owns the LFSR's clock-enable and reseed strobes and builds frames: fixed preamble symbols, then LFSR payload symbols, then an idle gap.
- Presents 4-bit symbols to the downstream mapper over a valid/ready handshake.
- Supports single-shot and continuous frame modes.

Parameters:
- PRE_LEN, 4: preamble symbols per frame; legal range 1..255.
- PRE_SYM_A, 4'b0000: preamble symbol at even preamble index (0, 2, ...).
- PRE_SYM_B, 4'b1111: preamble symbol at odd preamble index.
- GAP_CYCLES, 2: idle cycles after each frame; 0 is legal.
- RESEED_EACH_FRAME, 1: 1 = reseed LFSR before every frame; 0 = reseed only on the first frame after IDLE.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request to begin; ignored unless in IDLE
- continuous  in  1  sampled with start; 1 = repeat frames until stop
- stop  in  1  pulse; in continuous mode, ends after the current frame's GAP
- frame_len  in  12  payload symbols per frame; sampled on accepted start
- lfsr_sym_in  in  4  LFSR symbol output
- lfsr_clk_en  out  1  LFSR advance strobe
- lfsr_reset  out  1  LFSR reseed strobe
- sym_out  out  4  symbol to mapper
- sym_valid  out  1  symbol valid
- sym_ready  in  1  downstream accept
- sym_first  out  1  qualifies the first symbol of a frame
- sym_last  out  1  qualifies the last symbol of a frame
- busy  out  1  high in any state except IDLE
- frame_done  out  1  one-cycle pulse after the last symbol of a frame is accepted
- frame_count  out  16  completed frames since reset; wraps 0xFFFF->0

Behaviour:
- Reset (synchronous): state=IDLE.
  - sym_valid, sym_first, sym_last, lfsr_clk_en, busy, frame_done = 0; lfsr_reset = 1 while reset is high; frame_count = 0.
  - Internal counters, latched frame_len, latched mode and stop_pend all cleared.
- Handshake:
  - A symbol is transferred on a cycle with sym_valid & sym_ready.
  - While sym_valid=1 and sym_ready=0, sym_out, sym_first and sym_last hold stable.
  - sym_valid never drops without a transfer, except on reset.
- FSM: IDLE -> SEED -> PRE -> PAY -> GAP -> (SEED or PRE or IDLE).
- IDLE:
  - Outputs inactive.
  - start=1: latch frame_len and continuous, then go to SEED (first frame always seeds).
- SEED:
  - Exactly one cycle, lfsr_reset=1 (registered output); then go to PRE.
- PRE:
  - sym_valid=1; sym_out = PRE_SYM_A or PRE_SYM_B by preamble index.
  - sym_first=1 on index 0.
  - The index advances only on a transfer; after transfer of index PRE_LEN-1, go to PAY.
  - Latched frame_len=0: sym_last=1 on index PRE_LEN-1 and go to GAP instead.
- PAY:
  - sym_valid=1; sym_out = lfsr_sym_in (combinational pass-through).
  - lfsr_clk_en = sym_valid & sym_ready, combinational, asserted only in PAY, so the LFSR advances exactly once per accepted payload symbol.
  - The payload counter counts transfers; sym_last=1 on payload index frame_len-1.
  - On that transfer, go to GAP.
- frame_done and frame_count:
  - frame_done pulses the cycle after the sym_last transfer.
  - frame_count increments on that same edge.
- GAP:
  - sym_valid=0 for GAP_CYCLES cycles; with GAP_CYCLES=0, one pass-through cycle.
  - Exit to IDLE if single-shot, or if continuous with stop_pend set.
  - Otherwise exit to SEED if RESEED_EACH_FRAME=1, else to PRE.
- stop:
  - Sets stop_pend in any non-IDLE state; cleared on entering IDLE.
  - Never truncates a frame in progress.
  - stop in IDLE is ignored.
- lfsr_clk_en is never asserted outside PAY; lfsr_reset is never asserted outside SEED or reset.
- start while busy is ignored; the latched frame_len and mode are unchanged mid-run.
- Reset mid-frame: immediate return to IDLE; the partial frame is not counted and frame_done is not pulsed.

Test Plan:
- Single frame, PRE_LEN=4, frame_len=8, sym_ready=1, start at cycle 0:
  - lfsr_reset=1 at cycle 1; sym_valid rises cycle 2.
  - sym_out sequence 0,F,0,F then 8 LFSR symbols; sym_first on the 1st, sym_last on the 12th.
  - lfsr_clk_en high exactly 8 cycles; frame_done one pulse; frame_count=1; busy low after GAP.
- Backpressure: sym_ready toggles 1,0,0,1 during PAY:
  - sym_out and sym_last stable across stalled cycles; lfsr_clk_en only on ready cycles.
  - Payload symbols equal a golden LFSR model advanced 8 times.
- Continuous, RESEED_EACH_FRAME=1, frame_len=3, stop issued mid-frame 2:
  - Frames 1 and 2 have identical payload; frame 2 completes fully; exactly 2 frame_done pulses; IDLE afterwards.
- Continuous, RESEED_EACH_FRAME=0:
  - Frame 2 payload continues the LFSR sequence (symbol 4 onward), with no lfsr_reset between frames.
- frame_len=0:
  - 4 preamble symbols, sym_last on the 4th, zero lfsr_clk_en pulses, frame_count=1.
- Reset asserted during payload symbol 5 of 8:
  - Next cycle sym_valid=0, busy=0, frame_count unchanged, no frame_done.
  - start pressed during a run has no effect on frame length or count.

Source files
------------

// File: rtl/lfsr_frame_sched_if.sv
// Symbol handshake between the frame scheduler (master) and the downstream mapper (slave).
interface lfsr_frame_sched_if;
    logic [3:0] sym_out;
    logic       sym_valid;
    logic       sym_ready;
    logic       sym_first;
    logic       sym_last;

    modport master (output sym_out, sym_valid, sym_first, sym_last, input sym_ready);
    modport slave  (input sym_out, sym_valid, sym_first, sym_last, output sym_ready);
endinterface

// File: rtl/lfsr_frame_sched.sv
// Frame sequencer for the LFSR test-data source: preamble, LFSR payload, idle gap.
//   state | meaning
//   IDLE  | waiting for start, outputs inactive
//   SEED  | one-cycle LFSR reseed strobe
//   PRE   | fixed preamble symbols A/B alternating
//   PAY   | LFSR payload, one advance per accepted symbol
//   GAP   | idle cycles between frames
module lfsr_frame_sched #(
    parameter int unsigned PRE_LEN           = 4,
    parameter logic [3:0]  PRE_SYM_A         = 4'b0000,
    parameter logic [3:0]  PRE_SYM_B         = 4'b1111,
    parameter int unsigned GAP_CYCLES        = 2,
    parameter bit          RESEED_EACH_FRAME = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               continuous,
    input  logic               stop,
    input  logic [11:0]        frame_len,
    input  logic [3:0]         lfsr_sym_in,
    output logic               lfsr_clk_en,
    output logic               lfsr_reset,
    lfsr_frame_sched_if.master sym_if,
    output logic               busy,
    output logic               frame_done,
    output logic [15:0]        frame_count
);
    typedef enum logic [2:0] {S_IDLE, S_SEED, S_PRE, S_PAY, S_GAP} state_t;

    localparam logic [7:0]  PRE_LAST = 8'(PRE_LEN - 1);
    localparam logic [15:0] GAP_LOAD = (GAP_CYCLES == 0) ? 16'd0 : 16'(GAP_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  pre_idx_q, pre_idx_d;
    logic [11:0] pay_idx_q, pay_idx_d;
    logic [15:0] gap_cnt_q, gap_cnt_d;
    logic [11:0] len_q, len_d;
    logic        cont_q, cont_d;
    logic        stop_pend_q, stop_pend_d;
    logic        sym_valid_q, sym_valid_d;
    logic        sym_first_q, sym_first_d;
    logic        sym_last_q, sym_last_d;
    logic [3:0]  pre_sym_q, pre_sym_d;
    logic        busy_q, busy_d;
    logic        frame_done_q, frame_done_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic        lfsr_reset_q, lfsr_reset_d;
    logic        xfer;

    assign xfer = sym_valid_q & sym_if.sym_ready;

    always_comb begin
        state_d      = state_q;
        pre_idx_d    = pre_idx_q;
        pay_idx_d    = pay_idx_q;
        gap_cnt_d    = gap_cnt_q;
        len_d        = len_q;
        cont_d       = cont_q;
        stop_pend_d  = stop_pend_q;
        frame_done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d   = frame_len;
                    cont_d  = continuous;
                    state_d = S_SEED;
                end
            end
            S_SEED: begin
                pre_idx_d = 8'd0;
                state_d   = S_PRE;
            end
            S_PRE: begin
                if (xfer) begin
                    if (pre_idx_q == PRE_LAST) begin
                        if (len_q == 12'd0) begin
                            state_d      = S_GAP;
                            gap_cnt_d    = GAP_LOAD;
                            frame_done_d = 1'b1;
                        end else begin
                            state_d   = S_PAY;
                            pay_idx_d = 12'd0;
                        end
                    end else begin
                        pre_idx_d = pre_idx_q + 8'd1;
                    end
                end
            end
            S_PAY: begin
                if (xfer) begin
                    if (pay_idx_q == len_q - 12'd1) begin
                        state_d      = S_GAP;
                        gap_cnt_d    = GAP_LOAD;
                        frame_done_d = 1'b1;
                    end else begin
                        pay_idx_d = pay_idx_q + 12'd1;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_q == 16'd0) begin
                    // a stop arriving in the very last gap cycle still ends the run
                    if (!cont_q || stop_pend_q || stop) begin
                        state_d = S_IDLE;
                    end else if (RESEED_EACH_FRAME) begin
                        state_d = S_SEED;
                    end else begin
                        state_d   = S_PRE;
                        pre_idx_d = 8'd0;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q - 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (stop && state_q != S_IDLE) stop_pend_d = 1'b1;
        if (state_d == S_IDLE)         stop_pend_d = 1'b0;

        sym_valid_d   = (state_d == S_PRE) || (state_d == S_PAY);
        sym_first_d   = (state_d == S_PRE) && (pre_idx_d == 8'd0);
        sym_last_d    = ((state_d == S_PRE) && (pre_idx_d == PRE_LAST) && (len_q == 12'd0)) ||
                        ((state_d == S_PAY) && (pay_idx_d == len_q - 12'd1));
        pre_sym_d     = pre_idx_d[0] ? PRE_SYM_B : PRE_SYM_A;
        busy_d        = (state_d != S_IDLE);
        lfsr_reset_d  = (state_d == S_SEED);
        frame_count_d = frame_count_q + {15'd0, frame_done_d};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            pre_idx_q     <= 8'd0;
            pay_idx_q     <= 12'd0;
            gap_cnt_q     <= 16'd0;
            len_q         <= 12'd0;
            cont_q        <= 1'b0;
            stop_pend_q   <= 1'b0;
            sym_valid_q   <= 1'b0;
            sym_first_q   <= 1'b0;
            sym_last_q    <= 1'b0;
            pre_sym_q     <= 4'd0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= 16'd0;
            lfsr_reset_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pre_idx_q     <= pre_idx_d;
            pay_idx_q     <= pay_idx_d;
            gap_cnt_q     <= gap_cnt_d;
            len_q         <= len_d;
            cont_q        <= cont_d;
            stop_pend_q   <= stop_pend_d;
            sym_valid_q   <= sym_valid_d;
            sym_first_q   <= sym_first_d;
            sym_last_q    <= sym_last_d;
            pre_sym_q     <= pre_sym_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
            lfsr_reset_q  <= lfsr_reset_d;
        end
    end

    // payload symbols pass straight through; the LFSR only moves on acceptance, so they hold under stall
    assign sym_if.sym_out   = (state_q == S_PAY) ? lfsr_sym_in : pre_sym_q;
    assign sym_if.sym_valid = sym_valid_q;
    assign sym_if.sym_first = sym_first_q;
    assign sym_if.sym_last  = sym_last_q;
    assign lfsr_clk_en      = (state_q == S_PAY) & xfer;
    assign lfsr_reset       = lfsr_reset_q | reset;
    assign busy             = busy_q;
    assign frame_done       = frame_done_q;
    assign frame_count      = frame_count_q;
endmodule

// File: tb/tb_lfsr_frame_sched.sv
// Directed bench for lfsr_frame_sched: two instances (reseed-every-frame and free-running LFSR).
module tb_lfsr_frame_sched;
    localparam logic [21:0] LFSR_SEED = 22'h1A2B3C;

    logic        clk = 1'b0;
    logic        reset, start_a, start_b, continuous, stop, sym_ready;
    logic [11:0] frame_len;
    logic        lfsr_clk_en_a, lfsr_reset_a, busy_a, frame_done_a;
    logic        lfsr_clk_en_b, lfsr_reset_b, busy_b, frame_done_b;
    logic [15:0] frame_count_a, frame_count_b;
    logic [21:0] la, lb;

    lfsr_frame_sched_if ifa ();
    lfsr_frame_sched_if ifb ();
    assign ifa.sym_ready = sym_ready;
    assign ifb.sym_ready = sym_ready;

    always #5 clk = ~clk;

    lfsr_frame_sched dut_a (
        .clk(clk), .reset(reset), .start(start_a), .continuous(continuous), .stop(stop),
        .frame_len(frame_len), .lfsr_sym_in(la[3:0]), .lfsr_clk_en(lfsr_clk_en_a),
        .lfsr_reset(lfsr_reset_a), .sym_if(ifa.master), .busy(busy_a),
        .frame_done(frame_done_a), .frame_count(frame_count_a)
    );

    lfsr_frame_sched #(
        .PRE_LEN(3), .PRE_SYM_A(4'h5), .PRE_SYM_B(4'hA), .GAP_CYCLES(0), .RESEED_EACH_FRAME(1'b0)
    ) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .continuous(continuous), .stop(stop),
        .frame_len(frame_len), .lfsr_sym_in(lb[3:0]), .lfsr_clk_en(lfsr_clk_en_b),
        .lfsr_reset(lfsr_reset_b), .sym_if(ifb.master), .busy(busy_b),
        .frame_done(frame_done_b), .frame_count(frame_count_b)
    );

    function automatic logic [21:0] adv(input logic [21:0] s);
        return {s[20:0], s[21] ^ s[20]};
    endfunction

    // LFSR data sources driven by each scheduler's strobes
    always @(posedge clk) begin
        if (lfsr_reset_a) la <= LFSR_SEED;
        else if (lfsr_clk_en_a) la <= adv(la);
        if (lfsr_reset_b) lb <= LFSR_SEED;
        else if (lfsr_clk_en_b) lb <= adv(lb);
    end

    logic [3:0] xa_sym [512];
    logic       xa_first [512];
    logic       xa_last [512];
    logic [3:0] xb_sym [512];
    logic       xb_first [512];
    logic       xb_last [512];
    int na = 0, cen_a = 0, fd_a = 0, lr_a = 0;
    int nb = 0, cen_b = 0, fd_b = 0, lr_b = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (ifa.sym_valid && ifa.sym_ready) begin
                xa_sym[na % 512]   = ifa.sym_out;
                xa_first[na % 512] = ifa.sym_first;
                xa_last[na % 512]  = ifa.sym_last;
                na++;
            end
            if (lfsr_clk_en_a) cen_a++;
            if (frame_done_a)  fd_a++;
            if (lfsr_reset_a)  lr_a++;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (ifb.sym_valid && ifb.sym_ready) begin
                xb_sym[nb % 512]   = ifb.sym_out;
                xb_first[nb % 512] = ifb.sym_first;
                xb_last[nb % 512]  = ifb.sym_last;
                nb++;
            end
            if (lfsr_clk_en_b) cen_b++;
            if (frame_done_b)  fd_b++;
            if (lfsr_reset_b)  lr_b++;
        end
    end

    int total = 0;
    int bad   = 0;
    logic [3:0] gold [16];
    logic [3:0] exp_sym [32];
    logic       exp_first [32];
    logic       exp_last [32];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input int n);
        repeat (n) step();
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic build_frame(input int at, input int pre_len, input logic [3:0] a,
                               input logic [3:0] b, input int plen, input int goff);
        for (int i = 0; i < pre_len + plen; i++) begin
            exp_sym[at + i]   = (i < pre_len) ? ((i % 2 == 1) ? b : a) : gold[goff + i - pre_len];
            exp_first[at + i] = (i == 0);
            exp_last[at + i]  = (i == pre_len + plen - 1);
        end
    endtask

    task automatic cmp_q(input string tag, input int d, input int base, input int n);
        for (int i = 0; i < n; i++) begin
            int j;
            j = (base + i) % 512;
            chk($sformatf("%s_sym%0d", tag, i), 32'(d == 1 ? xb_sym[j] : xa_sym[j]), 32'(exp_sym[i]));
            chk($sformatf("%s_first%0d", tag, i), 32'(d == 1 ? xb_first[j] : xa_first[j]), 32'(exp_first[i]));
            chk($sformatf("%s_last%0d", tag, i), 32'(d == 1 ? xb_last[j] : xa_last[j]), 32'(exp_last[i]));
        end
    endtask

    int n0, c0, f0, r0, k;
    logic [3:0] s4;
    logic       prev_stall, prev_last;
    logic [3:0] prev_sym;
    logic       pat [4];
    logic [21:0] s;

    initial begin
        reset = 1'b1; start_a = 1'b0; start_b = 1'b0; continuous = 1'b0; stop = 1'b0;
        frame_len = 12'd0; sym_ready = 1'b1;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        s = LFSR_SEED;
        for (int i = 0; i < 16; i++) begin
            gold[i] = s[3:0];
            s = adv(s);
        end

        go(3);
        sample();
        chk("rst_lfsr_reset", 32'(lfsr_reset_a), 32'd1);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_valid", 32'(ifa.sym_valid), 32'd0);
        chk("rst_count", 32'(frame_count_a), 32'd0);
        chk("rst_clk_en", 32'(lfsr_clk_en_a), 32'd0);
        step();
        reset = 1'b0;
        go(2);

        // reset during payload symbol 5 of 8, with a stray start mid-run
        f0 = fd_a;
        frame_len = 12'd8; start_a = 1'b1;
        step(); start_a = 1'b0;
        go(3);
        frame_len = 12'd2; start_a = 1'b1;
        step(); start_a = 1'b0;
        go(2);
        sample();
        chk("t6_len_hold_valid7", 32'(ifa.sym_valid), 32'd1);
        chk("t6_len_hold_last7", 32'(ifa.sym_last), 32'd0);
        go(2);
        sample();
        chk("t6_len_hold_valid9", 32'(ifa.sym_valid), 32'd1);
        chk("t6_len_hold_last9", 32'(ifa.sym_last), 32'd0);
        step();
        sample();
        chk("t6_pay5_sym", 32'(ifa.sym_out), 32'(gold[4]));
        reset = 1'b1;
        step();
        sample();
        chk("t6_valid", 32'(ifa.sym_valid), 32'd0);
        chk("t6_busy", 32'(busy_a), 32'd0);
        chk("t6_frame_done", 32'(frame_done_a), 32'd0);
        chk("t6_count", 32'(frame_count_a), 32'd0);
        chk("t6_lfsr_reset", 32'(lfsr_reset_a), 32'd1);
        reset = 1'b0;
        go(4);
        chk("t6_no_done", 32'(fd_a - f0), 32'd0);
        chk("t6_count_after", 32'(frame_count_a), 32'd0);

        // single frame, frame_len=8, ready held high
        n0 = na; c0 = cen_a; f0 = fd_a; r0 = lr_a;
        frame_len = 12'd8; start_a = 1'b1;
        step(); start_a = 1'b0;
        sample();
        chk("t1_seed_c1", 32'(lfsr_reset_a), 32'd1);
        chk("t1_valid_c1", 32'(ifa.sym_valid), 32'd0);
        step();
        sample();
        chk("t1_valid_c2", 32'(ifa.sym_valid), 32'd1);
        chk("t1_first_c2", 32'(ifa.sym_first), 32'd1);
        chk("t1_lfsr_reset_c2", 32'(lfsr_reset_a), 32'd0);
        go(11);
        sample();
        chk("t1_last_c13", 32'(ifa.sym_last), 32'd1);
        chk("t1_sym_c13", 32'(ifa.sym_out), 32'(gold[7]));
        chk("t1_clk_en_c13", 32'(lfsr_clk_en_a), 32'd1);
        step();
        sample();
        chk("t1_done_c14", 32'(frame_done_a), 32'd1);
        chk("t1_count_c14", 32'(frame_count_a), 32'd1);
        chk("t1_valid_c14", 32'(ifa.sym_valid), 32'd0);
        step();
        sample();
        chk("t1_done_c15", 32'(frame_done_a), 32'd0);
        chk("t1_busy_c15", 32'(busy_a), 32'd1);
        step();
        sample();
        chk("t1_busy_c16", 32'(busy_a), 32'd0);
        step();
        chk("t1_xfers", 32'(na - n0), 32'd12);
        build_frame(0, 4, 4'h0, 4'hF, 8, 0);
        cmp_q("t1", 0, n0, 12);
        chk("t1_clk_en_cnt", 32'(cen_a - c0), 32'd8);
        chk("t1_done_cnt", 32'(fd_a - f0), 32'd1);
        chk("t1_seed_cnt", 32'(lr_a - r0), 32'd1);

        // backpressure during payload: ready 1,0,0,1 repeating
        n0 = na; c0 = cen_a; f0 = fd_a;
        frame_len = 12'd8; start_a = 1'b1;
        step(); start_a = 1'b0;
        go(5);
        prev_stall = 1'b0; prev_sym = 4'd0; prev_last = 1'b0; k = 0;
        while (busy_a && k < 40) begin
            sym_ready = pat[k % 4];
            sample();
            if (prev_stall) begin
                chk("t2_stall_sym", 32'(ifa.sym_out), 32'(prev_sym));
                chk("t2_stall_last", 32'(ifa.sym_last), 32'(prev_last));
            end
            if (ifa.sym_valid && !sym_ready) chk("t2_stall_clk_en", 32'(lfsr_clk_en_a), 32'd0);
            prev_stall = ifa.sym_valid && !sym_ready;
            prev_sym   = ifa.sym_out;
            prev_last  = ifa.sym_last;
            step();
            k++;
        end
        chk("t2_finished", 32'(busy_a), 32'd0);
        sym_ready = 1'b1;
        step();
        chk("t2_xfers", 32'(na - n0), 32'd12);
        build_frame(0, 4, 4'h0, 4'hF, 8, 0);
        cmp_q("t2", 0, n0, 12);
        chk("t2_clk_en_cnt", 32'(cen_a - c0), 32'd8);
        chk("t2_done_cnt", 32'(fd_a - f0), 32'd1);
        chk("t2_count", 32'(frame_count_a), 32'd2);

        // continuous with reseed each frame, stop during frame 2
        n0 = na; c0 = cen_a; f0 = fd_a; r0 = lr_a;
        frame_len = 12'd3; continuous = 1'b1; start_a = 1'b1;
        step(); start_a = 1'b0;
        go(12);
        stop = 1'b1;
        step(); stop = 1'b0;
        k = 0;
        while (busy_a && k < 60) begin
            step();
            k++;
        end
        chk("t3_idle", 32'(busy_a), 32'd0);
        continuous = 1'b0;
        step();
        chk("t3_xfers", 32'(na - n0), 32'd14);
        build_frame(0, 4, 4'h0, 4'hF, 3, 0);
        build_frame(7, 4, 4'h0, 4'hF, 3, 0);
        cmp_q("t3", 0, n0, 14);
        chk("t3_done_cnt", 32'(fd_a - f0), 32'd2);
        chk("t3_seed_cnt", 32'(lr_a - r0), 32'd2);
        chk("t3_clk_en_cnt", 32'(cen_a - c0), 32'd6);
        chk("t3_count", 32'(frame_count_a), 32'd4);

        // continuous without reseed, zero gap, on the second instance
        n0 = nb; c0 = cen_b; f0 = fd_b; r0 = lr_b;
        frame_len = 12'd3; continuous = 1'b1; start_b = 1'b1;
        step(); start_b = 1'b0;
        go(9);
        stop = 1'b1;
        step(); stop = 1'b0;
        k = 0;
        while (busy_b && k < 60) begin
            step();
            k++;
        end
        chk("t4_idle", 32'(busy_b), 32'd0);
        continuous = 1'b0;
        step();
        chk("t4_xfers", 32'(nb - n0), 32'd12);
        build_frame(0, 3, 4'h5, 4'hA, 3, 0);
        build_frame(6, 3, 4'h5, 4'hA, 3, 3);
        cmp_q("t4", 1, n0, 12);
        chk("t4_done_cnt", 32'(fd_b - f0), 32'd2);
        chk("t4_seed_cnt", 32'(lr_b - r0), 32'd1);
        chk("t4_clk_en_cnt", 32'(cen_b - c0), 32'd6);
        chk("t4_count", 32'(frame_count_b), 32'd2);

        // zero-length payload
        n0 = na; c0 = cen_a; f0 = fd_a;
        frame_len = 12'd0; start_a = 1'b1;
        step(); start_a = 1'b0;
        k = 0;
        while (busy_a && k < 40) begin
            step();
            k++;
        end
        chk("t5_idle", 32'(busy_a), 32'd0);
        step();
        chk("t5_xfers", 32'(na - n0), 32'd4);
        build_frame(0, 4, 4'h0, 4'hF, 0, 0);
        cmp_q("t5", 0, n0, 4);
        chk("t5_clk_en_cnt", 32'(cen_a - c0), 32'd0);
        chk("t5_done_cnt", 32'(fd_a - f0), 32'd1);
        chk("t5_count", 32'(frame_count_a), 32'd5);

        // stop while idle is ignored
        stop = 1'b1;
        step(); stop = 1'b0;
        sample();
        chk("t7_idle_stop_busy", 32'(busy_a), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
